// File: rtl/layer_addr_seq.sv
// Address sequencer for one fully-connected layer: walks every (neuron, input)
// pair and presents weight-read, neuron-read and neuron-write addresses per beat.
module layer_addr_seq #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BIAS_EN = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cfg_chain,
  input  logic [CNT_W-1:0]  cfg_nk,
  input  logic [CNT_W-1:0]  cfg_nk_prev,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_nr_base,
  input  logic [ADDR_W-1:0] cfg_nw_base,
  input  logic              advance,
  output logic              busy,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] nr_addr,
  output logic [ADDR_W-1:0] nw_addr,
  output logic              bias_beat,
  output logic              neuron_last,
  output logic              layer_last,
  output logic              done,
  output logic              size_err,
  output logic [CNT_W-1:0]  current_layer_size,
  output logic [CNT_W-1:0]  previous_layer_size
);

  // Input counter is one bit wider so P-1+BIAS never overflows.
  localparam int unsigned IW      = CNT_W + 1;
  localparam bit          BIAS_ON = (BIAS_EN != 0);
  localparam logic [IW-1:0] BIAS_I = IW'(BIAS_ON);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [CNT_W-1:0]  j_q, j_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  p_q, p_d;
  logic [ADDR_W-1:0] nr_base_q, nr_base_d;
  logic [ADDR_W-1:0] nw_base_q, nw_base_d;

  // Chain history of the last layer that finished normally.
  logic              hist_vld_q, hist_vld_d;
  logic [ADDR_W-1:0] last_w_q, last_w_d;
  logic [ADDR_W-1:0] last_nw_q, last_nw_d;
  logic [CNT_W-1:0]  last_n_q, last_n_d;

  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] nr_addr_q, nr_addr_d;
  logic [ADDR_W-1:0] nw_addr_q, nw_addr_d;
  logic              bias_q, bias_d;
  logic              nlast_q, nlast_d;
  logic              llast_q, llast_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  sel_p;
  logic [ADDR_W-1:0] sel_w, sel_nr, sel_nw;
  logic              run_d;
  logic [IW-1:0]     last_i;
  logic [IW-1:0]     nr_off;

  // Base/size selection for a start request: explicit config or chained.
  always_comb begin
    sel_p  = cfg_nk_prev;
    sel_w  = cfg_w_base;
    sel_nr = cfg_nr_base;
    sel_nw = cfg_nw_base;
    if (cfg_chain) begin
      sel_p  = last_n_q;
      sel_w  = hist_vld_q ? last_w_q + ADDR_W'(1) : '0;
      sel_nr = last_nw_q;
      sel_nw = last_nw_q + ADDR_W'(last_n_q);
    end
  end

  // Next-state, counters and next beat outputs.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    n_d        = n_q;
    p_d        = p_q;
    nr_base_d  = nr_base_q;
    nw_base_d  = nw_base_q;
    hist_vld_d = hist_vld_q;
    last_w_d   = last_w_q;
    last_nw_d  = last_nw_q;
    last_n_d   = last_n_q;
    w_addr_d   = w_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d = cfg_nk;
          p_d = sel_p;
          i_d = '0;
          j_d = '0;
          if ((cfg_nk == '0) || (sel_p == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_RUN;
            w_addr_d  = sel_w;
            nr_base_d = sel_nr;
            nw_base_d = sel_nw;
          end
        end
      end
      S_RUN: begin
        if (advance) begin
          if (llast_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            hist_vld_d = 1'b1;
            last_w_d   = w_addr_q;
            last_nw_d  = nw_base_q;
            last_n_d   = n_q;
          end else begin
            w_addr_d = w_addr_q + ADDR_W'(1);
            if (nlast_q) begin
              i_d = '0;
              j_d = j_q + CNT_W'(1);
            end else begin
              i_d = i_q + IW'(1);
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    run_d   = (state_d == S_RUN);
    last_i  = IW'(p_d) + BIAS_I - IW'(1);
    nr_off  = (i_d >= IW'(p_d)) ? IW'(p_d) - IW'(1) : i_d;
    busy_d  = run_d;
    valid_d = run_d;
    nlast_d = run_d && (i_d == last_i);
    llast_d = nlast_d && (j_d == n_d - CNT_W'(1));
    bias_d  = run_d && BIAS_ON && (i_d == IW'(p_d));
    nr_addr_d = run_d ? nr_base_d + ADDR_W'(nr_off) : '0;
    nw_addr_d = run_d ? nw_base_d + ADDR_W'(j_d) : '0;
    if (!run_d) begin
      w_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      n_q        <= '0;
      p_q        <= '0;
      nr_base_q  <= '0;
      nw_base_q  <= '0;
      hist_vld_q <= 1'b0;
      last_w_q   <= '0;
      last_nw_q  <= '0;
      last_n_q   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      w_addr_q   <= '0;
      nr_addr_q  <= '0;
      nw_addr_q  <= '0;
      bias_q     <= 1'b0;
      nlast_q    <= 1'b0;
      llast_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      n_q        <= n_d;
      p_q        <= p_d;
      nr_base_q  <= nr_base_d;
      nw_base_q  <= nw_base_d;
      hist_vld_q <= hist_vld_d;
      last_w_q   <= last_w_d;
      last_nw_q  <= last_nw_d;
      last_n_q   <= last_n_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      w_addr_q   <= w_addr_d;
      nr_addr_q  <= nr_addr_d;
      nw_addr_q  <= nw_addr_d;
      bias_q     <= bias_d;
      nlast_q    <= nlast_d;
      llast_q    <= llast_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy                = busy_q;
  assign addr_valid          = valid_q;
  assign w_addr              = w_addr_q;
  assign nr_addr             = nr_addr_q;
  assign nw_addr             = nw_addr_q;
  assign bias_beat           = bias_q;
  assign neuron_last         = nlast_q;
  assign layer_last          = llast_q;
  assign done                = done_q;
  assign size_err            = err_q;
  assign current_layer_size  = n_q;
  assign previous_layer_size = p_q;

endmodule
